// File: rtl/conv_capture_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | conv_capture_pkg                                                 |
// | Register map, CTRL bit positions and FSM encoding for capture.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package conv_capture_pkg;
  localparam logic [31:0] c_ADDR_CTRL   = 32'h0000_0000;
  localparam logic [31:0] c_ADDR_THRESH = 32'h0000_0001;
  localparam logic [31:0] c_ADDR_STATUS = 32'h0000_0002;
  localparam logic [31:0] c_BUF_BASE    = 32'h0000_0400;

  localparam int c_CTRL_ARM   = 0;
  localparam int c_CTRL_ABORT = 1;
  localparam int c_CTRL_FORCE = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;
endpackage
`default_nettype wire

// File: rtl/conv_capture_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | conv_capture_ram                                                 |
// | Simple dual-port RAM, registered read with one-cycle latency.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module conv_capture_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end
endmodule
`default_nettype wire

// File: rtl/conv_capture_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | conv_capture_buffer                                              |
// | Threshold/forced trigger capture of a sample stream, APB readout.|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module conv_capture_buffer #(
  parameter int DATA_BITWIDTH = 16,
  parameter int CAPTURE_DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     data_in_enable,
  input  logic [DATA_BITWIDTH-1:0] data_in,
  input  logic                     p_sel,
  input  logic [3:0]               p_strb,
  input  logic [31:0]              p_addr,
  input  logic [31:0]              p_wdata,
  input  logic                     p_ce,
  input  logic                     p_we,
  output logic                     p_rdy,
  output logic [31:0]              p_rdata,
  output logic                     trig_out,
  output logic                     capture_done
);
  import conv_capture_pkg::*;

  localparam int AW = $clog2(CAPTURE_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]            c_DEPTH   = CW'(CAPTURE_DEPTH);
  localparam logic [DATA_BITWIDTH-1:0] c_THR_RST = DATA_BITWIDTH'(32'h8000);

  state_t                   r_state, w_state_nxt;
  logic [CW-1:0]            r_count, w_count_nxt;
  logic [DATA_BITWIDTH-1:0] r_prev, w_prev_nxt, r_thr, w_thr_nxt;
  logic                     r_pv, w_pv_nxt, r_force, w_force_nxt;
  logic                     r_rdy, r_trig, w_trig, r_rd_buf;
  logic [31:0]              r_rd_reg, w_rd_reg;
  logic                     w_we;
  logic [AW-1:0]            w_waddr;
  logic [DATA_BITWIDTH-1:0] w_ram_rdata;

  wire w_access  = p_sel && p_ce && !r_rdy;
  wire w_wr      = w_access && p_we;
  wire w_ctrl    = w_wr && (p_addr == c_ADDR_CTRL) && p_strb[0];
  wire w_thr_wr  = w_wr && (p_addr == c_ADDR_THRESH);
  wire w_buf_hit = (p_addr >= c_BUF_BASE) && (p_addr < c_BUF_BASE + 32'(CAPTURE_DEPTH));
  wire w_done    = (r_state == ST_DONE);
  // A CTRL commit on the same edge as a strobe drops that sample.
  wire w_sample  = data_in_enable && !w_ctrl;
  wire w_unused_ok = &{1'b0, p_wdata, p_strb};

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_prev_nxt  = r_prev;
    w_pv_nxt    = r_pv;
    w_force_nxt = r_force;
    w_trig      = 1'b0;
    w_we        = 1'b0;
    w_waddr     = r_count[AW-1:0];
    if (w_ctrl) begin
      if (p_wdata[c_CTRL_ABORT]) begin
        w_state_nxt = ST_IDLE;
        w_count_nxt = '0;
        w_force_nxt = 1'b0;
      end else if (p_wdata[c_CTRL_ARM]) begin
        w_state_nxt = ST_ARMED;
        w_count_nxt = '0;
        w_pv_nxt    = 1'b0;
        w_force_nxt = p_wdata[c_CTRL_FORCE];
      end else if (p_wdata[c_CTRL_FORCE] && r_state == ST_ARMED) begin
        w_force_nxt = 1'b1;
      end
    end else if (w_sample) begin
      case (r_state)
        ST_ARMED: begin
          w_prev_nxt = data_in;
          w_pv_nxt   = 1'b1;
          if (r_force || (r_pv && r_prev < r_thr && data_in >= r_thr)) begin
            w_we        = 1'b1;
            w_waddr     = '0;
            w_count_nxt = CW'(1);
            w_state_nxt = ST_CAPTURE;
            w_force_nxt = 1'b0;
            w_trig      = 1'b1;
          end
        end
        ST_CAPTURE: begin
          w_we        = 1'b1;
          w_count_nxt = r_count + 1'b1;
          if (w_count_nxt == c_DEPTH) w_state_nxt = ST_DONE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_thr_nxt = r_thr;
    for (int i = 0; i < DATA_BITWIDTH; i++)
      if (p_strb[i/8]) w_thr_nxt[i] = p_wdata[i];
  end

  always_comb begin
    w_rd_reg = 32'd0;
    if (p_addr == c_ADDR_THRESH)      w_rd_reg = 32'(r_thr);
    else if (p_addr == c_ADDR_STATUS) w_rd_reg = {16'(r_count), 13'd0, w_done, r_state};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_prev   <= '0;
      r_pv     <= 1'b0;
      r_force  <= 1'b0;
      r_thr    <= c_THR_RST;
      r_rdy    <= 1'b0;
      r_trig   <= 1'b0;
      r_rd_buf <= 1'b0;
      r_rd_reg <= 32'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_prev   <= w_prev_nxt;
      r_pv     <= w_pv_nxt;
      r_force  <= w_force_nxt;
      r_rdy    <= w_access;
      r_trig   <= w_trig;
      r_rd_buf <= w_access && !p_we && w_buf_hit;
      r_rd_reg <= (w_access && !p_we) ? w_rd_reg : 32'd0;
      if (w_thr_wr) r_thr <= w_thr_nxt;
    end
  end

  // Buffer base is aligned above the largest depth, so low address bits index the RAM.
  conv_capture_ram #(
    .DEPTH (CAPTURE_DEPTH),
    .WIDTH (DATA_BITWIDTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (data_in),
    .i_raddr (p_addr[AW-1:0]),
    .o_rdata (w_ram_rdata)
  );

  assign p_rdy        = r_rdy;
  assign p_rdata      = !r_rdy ? 32'd0 : (r_rd_buf ? 32'(w_ram_rdata) : r_rd_reg);
  assign trig_out     = r_trig;
  assign capture_done = w_done;
endmodule
`default_nettype wire

// File: tb/tb_conv_capture_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_conv_capture_buffer                                           |
// | Directed bench for the capture buffer with immediate assertions. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_conv_capture_buffer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_in_enable = 1'b0;
  logic [15:0] data_in = 16'd0;
  logic        p_sel = 1'b0, p_ce = 1'b0, p_we = 1'b0;
  logic [3:0]  p_strb = 4'd0;
  logic [31:0] p_addr = 32'd0, p_wdata = 32'd0;
  logic        p_rdy, trig_out, capture_done;
  logic [31:0] p_rdata;
  logic [31:0] rd;
  int n_vec = 0;
  int n_err = 0;
  int trig_cnt = 0;

  always #5 clk = ~clk;

  conv_capture_buffer #(.DATA_BITWIDTH(16), .CAPTURE_DEPTH(256)) dut (
    .clk(clk), .rst(rst), .data_in_enable(data_in_enable), .data_in(data_in),
    .p_sel(p_sel), .p_strb(p_strb), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_ce(p_ce), .p_we(p_we), .p_rdy(p_rdy), .p_rdata(p_rdata),
    .trig_out(trig_out), .capture_done(capture_done)
  );

  always @(negedge clk) if (trig_out) trig_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apb(input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, input logic we, output logic [31:0] rdata);
    @(negedge clk);
    p_sel = 1'b1; p_ce = 1'b1; p_we = we; p_addr = addr; p_wdata = wdata; p_strb = strb;
    @(posedge clk); #1;
    chk("p_rdy_pulse", {31'd0, p_rdy}, 32'd1);
    rdata = p_rdata;
    p_sel = 1'b0; p_ce = 1'b0; p_we = 1'b0;
    @(posedge clk); #1;
    chk("p_rdy_single", {31'd0, p_rdy}, 32'd0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
    logic [31:0] dummy;
    apb(addr, wdata, strb, 1'b1, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    apb(addr, 32'd0, 4'd0, 1'b0, v);
    chk(tag, v, exp);
  endtask

  task automatic sample(input logic [15:0] d);
    @(negedge clk);
    data_in = d; data_in_enable = 1'b1;
    @(posedge clk); #1;
    data_in_enable = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("rst_p_rdy", {31'd0, p_rdy}, 32'd0);
    chk("rst_p_rdata", p_rdata, 32'd0);
    chk("rst_trig", {31'd0, trig_out}, 32'd0);
    chk("rst_done", {31'd0, capture_done}, 32'd0);
    rd_chk("rst_status", 32'h2, 32'h0000_0000);
    rd_chk("rst_thresh", 32'h1, 32'h0000_8000);
    sample(16'hFFFF); sample(16'h0000); sample(16'hFFFF);
    rd_chk("idle_samples_status", 32'h2, 32'h0000_0000);
    rd_chk("unmapped_read", 32'h3, 32'h0000_0000);

    // threshold capture ramp
    wr(32'h1, 32'h0000_9000, 4'hF);
    wr(32'h0, 32'h1, 4'h1);
    rd_chk("armed_status", 32'h2, 32'h0000_0001);
    sample(16'h8F00); chk("ramp_no_trig0", {31'd0, trig_out}, 32'd0);
    sample(16'h8F80); chk("ramp_no_trig1", {31'd0, trig_out}, 32'd0);
    sample(16'h9000); chk("ramp_trig", {31'd0, trig_out}, 32'd1);
    for (int k = 0; k < 254; k++) sample(16'h9001 + 16'(k));
    chk("trig_once", 32'(trig_cnt), 32'd1);
    chk("not_done_at_255", {31'd0, capture_done}, 32'd0);
    sample(16'h90FF);
    chk("done_at_256", {31'd0, capture_done}, 32'd1);
    rd_chk("done_status", 32'h2, 32'h0100_0007);
    rd_chk("word0", 32'h400, 32'h0000_9000);
    rd_chk("word1", 32'h401, 32'h0000_9001);
    rd_chk("word255", 32'h4FF, 32'h0000_90FF);
    sample(16'h1111);
    rd_chk("done_holds", 32'h2, 32'h0100_0007);
    wr(32'h2, 32'hFFFF_FFFF, 4'hF);
    rd_chk("status_ro", 32'h2, 32'h0100_0007);

    // first sample after ARM cannot trigger
    wr(32'h0, 32'h1, 4'h1);
    rd_chk("rearm_status", 32'h2, 32'h0000_0001);
    sample(16'hA000); chk("first_no_trig", {31'd0, trig_out}, 32'd0);
    sample(16'h8000); chk("second_no_trig", {31'd0, trig_out}, 32'd0);
    sample(16'h9500); chk("third_trig", {31'd0, trig_out}, 32'd1);
    rd_chk("fs_word0", 32'h400, 32'h0000_9500);
    rd_chk("fs_status", 32'h2, 32'h0001_0002);

    // forced trigger, gaps, abort at count 10
    wr(32'h0, 32'h1, 4'h1);
    wr(32'h0, 32'h4, 4'h1);
    rd_chk("force_pending", 32'h2, 32'h0000_0001);
    sample(16'h1234); chk("force_trig", {31'd0, trig_out}, 32'd1);
    rd_chk("force_word0", 32'h400, 32'h0000_1234);
    repeat (5) @(negedge clk);
    rd_chk("gap_status", 32'h2, 32'h0001_0002);
    for (int k = 0; k < 9; k++) sample(16'h2000 + 16'(k));
    rd_chk("count10_status", 32'h2, 32'h000A_0002);
    rd_chk("word9", 32'h409, 32'h0000_2008);
    wr(32'h0, 32'h2, 4'h1);
    rd_chk("abort_status", 32'h2, 32'h0000_0000);
    wr(32'h0, 32'h4, 4'h1);
    sample(16'h5555); chk("force_idle_ignored", {31'd0, trig_out}, 32'd0);
    rd_chk("force_idle_status", 32'h2, 32'h0000_0000);
    wr(32'h0, 32'h1, 4'h1);
    wr(32'h0, 32'h3, 4'h1);
    rd_chk("arm_abort_status", 32'h2, 32'h0000_0000);

    // byte strobe on THRESHOLD
    wr(32'h1, 32'h0000_ABCD, 4'h1);
    rd_chk("thr_strb_lo", 32'h1, 32'h0000_90CD);

    // reset mid-capture
    wr(32'h0, 32'h1, 4'h1);
    wr(32'h0, 32'h4, 4'h1);
    sample(16'h7777);
    rd_chk("pre_rst_status", 32'h2, 32'h0001_0002);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    rd_chk("post_rst_status", 32'h2, 32'h0000_0000);
    rd_chk("post_rst_thresh", 32'h1, 32'h0000_8000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
